// File: rtl/signed_arith_pkg.sv
// Shared constants for the signed add/subtract datapath.
//   OP_ADD / OP_SUB   : encoding of the op input
//   SAT_WRAP / SAT_ON : encoding of the saturation-mode register
package signed_arith_pkg;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;

    localparam logic SAT_WRAP = 1'b0;
    localparam logic SAT_ON   = 1'b1;

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice with a DW-bit payload.
//   clk, rst_n          : clock, async active-low reset
//   in_valid_i/_ready_o : upstream handshake, in_data_i payload
//   out_valid_o/_ready_i: downstream handshake, out_data_o payload
// The slice loads whenever it is empty or its current beat leaves this
// cycle, so a chain of slices streams one beat per cycle without a skid
// buffer; in_ready_o is therefore combinational from out_ready_i.
module pipe_stage #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          vld_q;
    logic [DW-1:0] data_q;

    assign in_ready_o  = !vld_q || out_ready_i;
    assign out_valid_o = vld_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_ready_o) begin
            vld_q <= in_valid_i;
            // Payload only moves with a real beat so a held output stays put.
            if (in_valid_i) data_q <= in_data_i;
        end
    end

endmodule

// File: rtl/signed_addsub_pipe.sv
// Two-stage signed add/subtract with optional saturation.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (num1, num2, op)
//   sat_wr/sat_in        : load the saturation-mode register
//   out_valid/out_ready  : result handshake (s_out, ovf)
// S1 holds the exact WIDTH+1-bit result; S2 holds the wrapped or saturated
// WIDTH-bit result plus the overflow flag.
module signed_addsub_pipe
    import signed_arith_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter bit          SAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             op,
    input  logic             sat_wr,
    input  logic             sat_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s_out,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             sat_q, sat_d;
    logic [WIDTH:0]   a_ext, b_ext, res_d;
    logic             s1_vld, s2_rdy;
    logic [WIDTH:0]   s1_res;
    logic             ovf_d;
    logic [WIDTH-1:0] s_d;

    // Saturation mode: a write lands on the edge, so S2 sees it from the
    // next capture onward.
    assign sat_d = sat_wr ? sat_in : sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_q <= SAT_DEFAULT;
        else        sat_q <= sat_d;
    end

    // One extra bit keeps the result exact, so overflow is just a
    // disagreement between the top two bits.
    assign a_ext = {num1[WIDTH-1], num1};
    assign b_ext = {num2[WIDTH-1], num2};
    assign res_d = (op == OP_SUB) ? a_ext - b_ext : a_ext + b_ext;

    pipe_stage #(.DW(WIDTH+1)) u_s1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (res_d),
        .out_valid_o(s1_vld),
        .out_ready_i(s2_rdy),
        .out_data_o (s1_res)
    );

    assign ovf_d = s1_res[WIDTH] ^ s1_res[WIDTH-1];

    // The true sign is the top bit of the exact result.
    always_comb begin
        s_d = s1_res[WIDTH-1:0];
        if (ovf_d && (sat_q == SAT_ON))
            s_d = s1_res[WIDTH] ? MIN_NEG : MAX_POS;
    end

    pipe_stage #(.DW(WIDTH+1)) u_s2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (s1_vld),
        .in_ready_o (s2_rdy),
        .in_data_i  ({ovf_d, s_d}),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o ({ovf, s_out})
    );

endmodule

// File: tb/tb_signed_addsub_pipe.sv
module tb_signed_addsub_pipe;

    localparam logic [31:0] MAXP = 32'h7FFF_FFFF;
    localparam logic [31:0] MINN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] num1 = '0, num2 = '0;
    logic        op = 1'b0;
    logic        sat_wr = 1'b0, sat_in = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] s_out;
    logic        ovf;

    signed_addsub_pipe #(.WIDTH(32), .SAT_DEFAULT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .op(op),
        .sat_wr(sat_wr), .sat_in(sat_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .s_out(s_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic        op, sat;
        logic [31:0] s;
        logic        v;
    } vec_t;

    vec_t        vecs[13];
    int          n_cmp = 0, n_bad = 0;
    int          acc = 0;
    logic        sat_model = 1'b0;
    logic [32:0] exp_q[$];
    logic        hold_prev = 1'b0;
    logic [32:0] prev_out = '0;

    // Reference: exact 64-bit arithmetic, range test for overflow.
    function automatic logic [32:0] model(input logic [31:0] a, b, input logic o, s);
        longint r;
        logic v;
        logic [31:0] y;
        r = o ? longint'($signed(a)) - longint'($signed(b))
              : longint'($signed(a)) + longint'($signed(b));
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (v && s) y = (r > 0) ? MAXP : MINN;
        else        y = r[31:0];
        return {v, y};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One clock: observe handshakes just before the edge, return at posedge+1.
    task automatic tick();
        @(negedge clk);
        if (hold_prev) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'({ovf, s_out}), 64'(prev_out));
        end
        hold_prev = out_valid && !out_ready;
        prev_out  = {ovf, s_out};
        if (in_valid && in_ready) begin
            exp_q.push_back(model(num1, num2, op, sat_model));
            acc++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_beat: got %h, expected no beat", {ovf, s_out});
            end else begin
                check("stream_result", 64'({ovf, s_out}), 64'(exp_q.pop_front()));
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic set_mode(input logic v);
        sat_wr = 1'b1; sat_in = v;
        tick();
        sat_wr = 1'b0;
        sat_model = v;
    endtask

    task automatic apply_vec(input vec_t t, input string name);
        int lat;
        if (t.sat != sat_model) set_mode(t.sat);
        out_ready = 1'b1;
        num1 = t.a; num2 = t.b; op = t.op; in_valid = 1'b1;
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd2);
        check({name, "_s_out"}, 64'(s_out), 64'(t.s));
        check({name, "_ovf"}, 64'(ovf), 64'(t.v));
        tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return MAXP;
            1: return MINN;
            2: return 32'h0;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_random(input int n);
        int guard;
        acc = 0; guard = 0;
        while (acc < n && guard < n * 8) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            num1 = pick(); num2 = pick(); op = $urandom_range(0, 1);
            tick();
            guard++;
        end
        check("random_accepted", 64'(acc), 64'(n));
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
        check("random_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, %0d compared", n_cmp);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'd1010,      32'd1000,      1'b0, 1'b0, 32'd2010,      1'b0};
        vecs[1]  = '{MAXP,          32'd1,         1'b0, 1'b0, MINN,          1'b1};
        vecs[2]  = '{MINN,          32'd1,         1'b1, 1'b0, MAXP,          1'b1};
        vecs[3]  = '{32'd0,         MINN,          1'b1, 1'b0, MINN,          1'b1};
        vecs[4]  = '{32'hFFFF_FFFB, 32'd3,         1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0};
        vecs[5]  = '{MINN,          MINN,          1'b0, 1'b0, 32'd0,         1'b1};
        vecs[6]  = '{MAXP,          32'd1,         1'b0, 1'b1, MAXP,          1'b1};
        vecs[7]  = '{MINN,          32'd1,         1'b1, 1'b1, MINN,          1'b1};
        vecs[8]  = '{32'd0,         MINN,          1'b1, 1'b1, MAXP,          1'b1};
        vecs[9]  = '{MINN,          MINN,          1'b0, 1'b1, MINN,          1'b1};
        vecs[10] = '{MAXP,          32'hFFFF_FFFF, 1'b1, 1'b1, MAXP,          1'b1};
        vecs[11] = '{32'd1010,      32'd1000,      1'b0, 1'b1, 32'd2010,      1'b0};
        vecs[12] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 1'b1, 32'd0,         1'b0};

        // Reset state.
        @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s_out", 64'(s_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors; wrap mode first relies on the reset default.
        for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 8 beats offered, consumer stalled for 5 cycles.
        begin
            bit fell;
            int cyc;
            fell = 1'b0; acc = 0; cyc = 0;
            while ((acc < 8 || exp_q.size() > 0) && cyc < 60) begin
                out_ready = (cyc >= 5);
                in_valid  = (acc < 8);
                num1 = 32'd100 + 32'(acc) * 32'd3; num2 = 32'(acc); op = acc[0];
                if (in_valid && !in_ready && !fell) begin
                    check("bp_ready_fall_count", 64'(acc), 64'd2);
                    fell = 1'b1;
                end
                tick();
                cyc++;
            end
            in_valid = 1'b0; out_ready = 1'b1;
            check("bp_ready_fell", 64'(fell), 64'd1);
            check("bp_all_accepted", 64'(acc), 64'd8);
            check("bp_all_delivered", 64'(exp_q.size()), 64'd0);
        end

        // Reset with two beats in flight.
        out_ready = 1'b0; in_valid = 1'b1;
        num1 = 32'd5; num2 = 32'd6; op = 1'b0;
        tick(); tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_s_out", 64'(s_out), 64'd0);
        exp_q.delete(); hold_prev = 1'b0; sat_model = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_stale", 64'(out_valid), 64'd0);
            tick();
        end
        apply_vec(vecs[1], "after_rst");

        // Random streaming in both modes.
        run_random(5000);
        set_mode(1'b1);
        run_random(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/signed_addsub_pipe.md
SIGNED_ADDSUB_PIPE -- requirements
Module: signed_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits (legal range 2..64).
REQ-002 SHALL have parameter SAT_DEFAULT, default 0: value loaded into the saturation-mode register at reset.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 SHALL have port num1, input, WIDTH: signed two's-complement operand A.
REQ-008 SHALL have port num2, input, WIDTH: signed two's-complement operand B.
REQ-009 SHALL have port op, input, 1: 0 = add (A+B), 1 = subtract (A-B).
REQ-010 SHALL have port sat_wr, input, 1: pulse that loads sat_in into the mode register.
REQ-011 SHALL have port sat_in, input, 1: new saturation mode (1 = saturate, 0 = wrap).
REQ-012 SHALL have port out_valid, output, 1: result beat present.
REQ-013 SHALL have port out_ready, input, 1: consumer takes the beat this cycle.
REQ-014 SHALL have port s_out, output, WIDTH: signed result.
REQ-015 SHALL have port ovf, output, 1: signed overflow detected for this beat (set in both modes).

Function
REQ-016 SHALL transfer an input beat only when in_valid and in_ready are both 1 in the same cycle; an output beat transfers only when out_valid and out_ready are both 1.
REQ-017 SHALL implement two pipeline stages: S1 registers the exact WIDTH+1-bit sign-extended sum or difference; S2 registers s_out and ovf.
REQ-018 SHALL have a latency of exactly 2 cycles from input handshake to out_valid when out_ready is held 1.
REQ-019 SHALL sustain one beat per cycle when out_ready = 1.
REQ-020 SHALL advance each stage when that stage is empty or its contents move downstream in the same cycle; in_ready = !S1_valid | S1_advance, computed combinationally, with no skid buffer.
REQ-021 SHALL hold s_out, ovf and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL flag overflow when the top two bits of the WIDTH+1-bit result differ.
REQ-023 SHALL, in wrap mode, output the low WIDTH bits of the result.
REQ-024 SHALL, in saturate mode on overflow, output max positive (0111..1) if the result sign bit is 0 and min negative (1000..0) if it is 1.
REQ-025 SHALL treat subtraction of the most-negative value as a normal overflow case (0 - MIN gives ovf = 1 and, when saturating, max positive).
REQ-026 SHALL apply the saturation mode at the S2 capture cycle; sat_wr takes effect from the following cycle and does not stall the pipeline.
REQ-027 SHALL lose no beat and duplicate no beat under any pattern of in_valid/out_ready.

Reset
REQ-028 SHALL, while rst_n = 0, force S1/S2 valid flags to 0, out_valid to 0, s_out to 0, ovf to 0, and the mode register to SAT_DEFAULT.
REQ-029 SHALL drive in_ready to 1 in the first cycle after rst_n deasserts.
REQ-030 SHALL discard in-flight beats when reset asserts mid-operation; none reappear after release.

Structure
REQ-031 SHALL place the op encoding (OP_ADD = 0, OP_SUB = 1) and the saturation-mode constants in the shared package signed_arith_pkg.
REQ-032 SHALL implement each stage as an instance of one sub-module, pipe_stage (parametrised payload width, valid/ready register slice).

Verification (WIDTH = 32)
REQ-033 SHALL test a basic add: 1010 + 1000, op = 0 -> s_out = 2010, ovf = 0, out_valid 2 cycles after the handshake.
REQ-034 SHALL test wrap mode: 0x7FFFFFFF + 1 -> s_out = 0x80000000, ovf = 1; 0x80000000 - 1 -> 0x7FFFFFFF, ovf = 1.
REQ-035 SHALL test saturate mode (sat_wr with sat_in = 1): the same two beats -> 0x7FFFFFFF and 0x80000000, ovf = 1; 0 - 0x80000000 -> 0x7FFFFFFF.
REQ-036 SHALL test backpressure: 8 back-to-back beats with out_ready = 0 for 5 cycles -> in_ready falls after 2 beats accepted, output held stable, all 8 results delivered in order.
REQ-037 SHALL test reset mid-flight: rst_n pulled low with 2 beats in flight -> out_valid = 0 immediately, no stale result after release, and the next beat is correct.
REQ-038 SHALL test random streaming: 10k random operands, op and stalls checked against a reference model for both modes.
